uart_mmio_port: RTL and testbench

- Memory-mapped UART endpoint on the mmio_bus. It consumes the memory controller's UART strobes for the window 0xAAAAA400–0xAAAAA407.
- Contains a TX FIFO with serializer, an RX synchronizer with deserializer and RX FIFO, and a status register.
- Outputs `uart_dout` combinationally. The memory controller registers it on the same edge as the access.

---
 rtl/uart_mmio_port_if.sv | 20 ++
 rtl/uart_mmio_port.sv | 227 ++++++++++++++++++++++
 tb/tb_uart_mmio_port.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_mmio_port_if.sv
// rtl/uart_mmio_port_if.sv - mmio_bus UART strobe/data bundle between memory controller and UART
interface uart_mmio_port_if;
  logic       tx_wen;
  logic       rx_ren;
  logic [2:0] uart_addr;
  logic [7:0] uart_din;
  logic [7:0] uart_dout;
  logic       tx_full;
  logic       rx_data_present;

  modport master (
    output tx_wen, rx_ren, uart_addr, uart_din,
    input  uart_dout, tx_full, rx_data_present
  );

  modport slave (
    input  tx_wen, rx_ren, uart_addr, uart_din,
    output uart_dout, tx_full, rx_data_present
  );
endinterface

// File: rtl/uart_mmio_port.sv
// rtl/uart_mmio_port.sv - memory-mapped UART with TX/RX FIFOs, 16x oversampled serializer/deserializer
module uart_mmio_port #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic            clk,
  input  logic            Rst,
  uart_mmio_port_if.slave bus,
  output logic            tx,
  input  logic            rx
);
  localparam int DIV_RAW = CLK_FREQ / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam int AW      = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [CW-1:0] r_div_cnt;
  logic          w_tick;

  logic [7:0]    r_tx_mem [FIFO_DEPTH];
  logic [AW:0]   r_tx_wp, r_tx_rp;
  logic          w_tx_empty, w_tx_full, w_tx_push, w_tx_pop;
  logic [7:0]    w_tx_head;
  state_t        r_tx_state;
  logic [3:0]    r_tx_cnt;
  logic [2:0]    r_tx_bit;
  logic [7:0]    r_tx_shift;
  logic          r_tx_line;

  logic [7:0]    r_rx_mem [FIFO_DEPTH];
  logic [AW:0]   r_rx_wp, r_rx_rp;
  logic          w_rx_empty, w_rx_full, w_rx_push, w_rx_pop;
  logic [7:0]    w_rx_head;
  logic          r_rx_sync1, r_rx_sync2, w_rx_line;
  state_t        r_rx_state;
  logic [3:0]    r_rx_cnt;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;
  logic          w_rx_done, w_ovr_set, w_ferr_set, w_st_clr;
  logic          r_rx_ovr, r_frame_err;
  logic [7:0]    w_dout;

  assign w_tick     = (r_div_cnt == DIV_LAST);
  assign w_tx_empty = (r_tx_wp == r_tx_rp);
  assign w_tx_full  = (r_tx_wp[AW] != r_tx_rp[AW]) && (r_tx_wp[AW-1:0] == r_tx_rp[AW-1:0]);
  assign w_rx_empty = (r_rx_wp == r_rx_rp);
  assign w_rx_full  = (r_rx_wp[AW] != r_rx_rp[AW]) && (r_rx_wp[AW-1:0] == r_rx_rp[AW-1:0]);
  assign w_tx_head  = r_tx_mem[r_tx_rp[AW-1:0]];
  assign w_rx_head  = r_rx_mem[r_rx_rp[AW-1:0]];
  assign w_rx_line  = r_rx_sync2;

  assign w_tx_push  = bus.tx_wen && (bus.uart_addr == 3'd0) && !w_tx_full;
  // The serializer takes a new byte from IDLE or straight out of STOP so frames run back to back.
  assign w_tx_pop   = w_tick && !w_tx_empty &&
                      ((r_tx_state == S_IDLE) || ((r_tx_state == S_STOP) && (r_tx_cnt == 4'd15)));
  assign w_rx_pop   = bus.rx_ren && (bus.uart_addr == 3'd0) && !w_rx_empty;
  assign w_st_clr   = bus.rx_ren && (bus.uart_addr == 3'd4);
  assign w_rx_done  = w_tick && (r_rx_state == S_STOP) && (r_rx_cnt == 4'd15);
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign w_rx_push  = w_rx_done && w_rx_line && (!w_rx_full || w_rx_pop);
  assign w_ovr_set  = w_rx_done && w_rx_line && w_rx_full && !w_rx_pop;
  assign w_ferr_set = w_rx_done && !w_rx_line;

  assign tx                  = r_tx_line;
  assign bus.tx_full         = w_tx_full;
  assign bus.rx_data_present = !w_rx_empty;
  assign bus.uart_dout       = w_dout;

  // Read mux: DATA shows the RX head (0 when empty), STATUS packs flags, other offsets read 0.
  always_comb begin
    w_dout = 8'h00;
    case (bus.uart_addr)
      3'd0:    if (!w_rx_empty) w_dout = w_rx_head;
      3'd4:    w_dout = {3'b000, r_frame_err, r_rx_ovr,
                         (w_tx_empty && (r_tx_state == S_IDLE)), w_tx_full, !w_rx_empty};
      default: w_dout = 8'h00;
    endcase
  end

  // Oversample tick divider, 16 ticks per bit.
  always_ff @(posedge clk or negedge Rst)
    if (!Rst)        r_div_cnt <= '0;
    else if (w_tick) r_div_cnt <= '0;
    else             r_div_cnt <= r_div_cnt + 1'b1;

  // FIFO storage needs no reset; validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp[AW-1:0]] <= bus.uart_din;
    if (w_rx_push) r_rx_mem[r_rx_wp[AW-1:0]] <= r_rx_shift;
  end

  // FIFO pointers with wrap bit.
  always_ff @(posedge clk or negedge Rst)
    if (!Rst) begin
      r_tx_wp <= '0;
      r_tx_rp <= '0;
      r_rx_wp <= '0;
      r_rx_rp <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
    end

  // TX frame FSM driving a registered line.
  always_ff @(posedge clk or negedge Rst)
    if (!Rst) begin
      r_tx_state <= S_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_line  <= 1'b1;
    end else if (w_tick) begin
      case (r_tx_state)
        S_IDLE: begin
          r_tx_cnt <= '0;
          if (w_tx_pop) begin
            r_tx_shift <= w_tx_head;
            r_tx_state <= S_START;
            r_tx_line  <= 1'b0;
          end
        end
        S_START: begin
          r_tx_cnt <= r_tx_cnt + 1'b1;
          if (r_tx_cnt == 4'd15) begin
            r_tx_state <= S_DATA;
            r_tx_bit   <= '0;
            r_tx_line  <= r_tx_shift[0];
          end
        end
        S_DATA: begin
          r_tx_cnt <= r_tx_cnt + 1'b1;
          if (r_tx_cnt == 4'd15) begin
            if (r_tx_bit == 3'd7) begin
              r_tx_state <= S_STOP;
              r_tx_line  <= 1'b1;
            end else begin
              r_tx_bit   <= r_tx_bit + 1'b1;
              r_tx_shift <= r_tx_shift >> 1;
              r_tx_line  <= r_tx_shift[1];
            end
          end
        end
        S_STOP: begin
          r_tx_cnt <= r_tx_cnt + 1'b1;
          if (r_tx_cnt == 4'd15) begin
            if (w_tx_pop) begin
              r_tx_shift <= w_tx_head;
              r_tx_state <= S_START;
              r_tx_line  <= 1'b0;
            end else begin
              r_tx_state <= S_IDLE;
            end
          end
        end
      endcase
    end

  // Two-flop synchronizer for the asynchronous rx line.
  always_ff @(posedge clk or negedge Rst)
    if (!Rst) begin
      r_rx_sync1 <= 1'b1;
      r_rx_sync2 <= 1'b1;
    end else begin
      r_rx_sync1 <= rx;
      r_rx_sync2 <= r_rx_sync1;
    end

  // RX frame FSM: validate start at half bit, then sample each bit at mid-bit.
  always_ff @(posedge clk or negedge Rst)
    if (!Rst) begin
      r_rx_state <= S_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      case (r_rx_state)
        S_IDLE: begin
          if (!w_rx_line) begin
            r_rx_state <= S_START;
            r_rx_cnt   <= '0;
          end
        end
        S_START: if (w_tick) begin
          r_rx_cnt <= r_rx_cnt + 1'b1;
          if (r_rx_cnt == 4'd7) begin
            if (!w_rx_line) begin
              r_rx_state <= S_DATA;
              r_rx_cnt   <= '0;
              r_rx_bit   <= '0;
            end else begin
              r_rx_state <= S_IDLE;
            end
          end
        end
        S_DATA: if (w_tick) begin
          r_rx_cnt <= r_rx_cnt + 1'b1;
          if (r_rx_cnt == 4'd15) begin
            r_rx_shift <= {w_rx_line, r_rx_shift[7:1]};
            if (r_rx_bit == 3'd7) r_rx_state <= S_STOP;
            else                  r_rx_bit   <= r_rx_bit + 1'b1;
          end
        end
        S_STOP: if (w_tick) begin
          r_rx_cnt <= r_rx_cnt + 1'b1;
          if (r_rx_cnt == 4'd15) r_rx_state <= S_IDLE;
        end
      endcase
    end

  // Sticky error flags; a set in the clearing cycle wins.
  always_ff @(posedge clk or negedge Rst)
    if (!Rst) begin
      r_rx_ovr    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_ovr_set)     r_rx_ovr <= 1'b1;
      else if (w_st_clr) r_rx_ovr <= 1'b0;
      if (w_ferr_set)    r_frame_err <= 1'b1;
      else if (w_st_clr) r_frame_err <= 1'b0;
    end
endmodule

// File: tb/tb_uart_mmio_port.sv
// tb/tb_uart_mmio_port.sv - directed self-checking bench for uart_mmio_port
module tb_uart_mmio_port;
  logic clk = 1'b0;
  logic rst_n;
  logic tx;
  logic rx;
  int   n_vec = 0;
  int   n_err = 0;
  logic [7:0] d;

  uart_mmio_port_if bus();

  uart_mmio_port #(.CLK_FREQ(1600000), .BAUD(100000), .FIFO_DEPTH(16)) dut (
    .clk (clk),
    .Rst (rst_n),
    .bus (bus),
    .tx  (tx),
    .rx  (rx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] v);
    @(negedge clk);
    bus.tx_wen    = 1'b1;
    bus.uart_addr = a;
    bus.uart_din  = v;
    @(negedge clk);
    bus.tx_wen    = 1'b0;
    bus.uart_addr = 3'd0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] v);
    @(negedge clk);
    bus.rx_ren    = 1'b1;
    bus.uart_addr = a;
    #1 v = bus.uart_dout;
    @(negedge clk);
    bus.rx_ren    = 1'b0;
    bus.uart_addr = 3'd0;
  endtask

  task automatic peek(input logic [2:0] a, output logic [7:0] v);
    @(negedge clk);
    bus.uart_addr = a;
    #1 v = bus.uart_dout;
  endtask

  task automatic tx_frame(input logic [7:0] b, input bit wait_start, input string tag);
    logic [9:0] f;
    int errs;
    int n;
    f = {1'b1, b, 1'b0};
    errs = 0;
    if (wait_start) begin
      n = 0;
      while (tx !== 1'b0 && n < 400) begin
        @(negedge clk);
        n++;
      end
      if (tx !== 1'b0) begin
        check({tag, "_start_timeout"}, tx, 0);
        return;
      end
    end
    for (int i = 0; i < 160; i++) begin
      if (i > 0 || !wait_start) @(negedge clk);
      if (tx !== f[i/16]) errs++;
    end
    check(tag, errs, 0);
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx = f[i];
      repeat (15) @(negedge clk);
    end
    if (!stop_bit) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int errs;
    rst_n         = 1'b0;
    rx            = 1'b1;
    bus.tx_wen    = 1'b0;
    bus.rx_ren    = 1'b0;
    bus.uart_addr = 3'd0;
    bus.uart_din  = 8'h00;

    peek(3'd4, d);
    check("reset_status", d, 8'h04);
    check("reset_tx", tx, 1);
    @(negedge clk);
    rst_n = 1'b1;

    bus_write(3'd0, 8'h00);
    bus_write(3'd0, 8'h00);
    repeat (30) @(negedge clk);
    check("midframe_tx_low", tx, 0);
    #2 rst_n = 1'b0;
    #1 check("reset_tx_immediate", tx, 1);
    peek(3'd4, d);
    check("midreset_status", d, 8'h04);
    @(negedge clk);
    rst_n = 1'b1;
    errs = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) errs++;
    end
    check("post_reset_tx_idle", errs, 0);
    peek(3'd0, d);
    check("post_reset_data", d, 8'h00);

    bus_write(3'd0, 8'hA5);
    tx_frame(8'hA5, 1'b1, "tx_a5");
    repeat (3) @(negedge clk);
    peek(3'd4, d);
    check("status_after_a5", d, 8'h04);

    bus_write(3'd4, 8'h00);
    repeat (20) @(negedge clk);
    check("addr4_write_ignored_tx", tx, 1);
    peek(3'd4, d);
    check("addr4_write_ignored_status", d, 8'h04);

    fork
      begin
        bus_write(3'd0, 8'h55);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 17; k++) begin
          bus_write(3'd0, k[7:0]);
          if (k == 14) check("tx_full_after_15", bus.tx_full, 0);
          if (k == 15) check("tx_full_after_16", bus.tx_full, 1);
        end
        check("tx_full_after_17", bus.tx_full, 1);
      end
      begin
        tx_frame(8'h55, 1'b1, "tx_lead_55");
        for (int k = 0; k < 16; k++)
          tx_frame(k[7:0], 1'b0, $sformatf("tx_stream_%0d", k));
      end
    join
    errs = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) errs++;
    end
    check("tx_10_dropped", errs, 0);
    peek(3'd4, d);
    check("status_after_stream", d, 8'h04);

    rx_send(8'h3C, 1'b1);
    check("rx_present_before", bus.rx_data_present, 1);
    peek(3'd2, d);
    check("odd_offset_reads_0", d, 8'h00);
    peek(3'd0, d);
    check("peek_no_pop", d, 8'h3C);
    bus_read(3'd0, d);
    check("rx_3c", d, 8'h3C);
    check("rx_present_after", bus.rx_data_present, 0);

    for (int k = 0; k < 17; k++) rx_send(8'h40 + k[7:0], 1'b1);
    repeat (4) @(negedge clk);
    peek(3'd4, d);
    check("status_overrun", d & 8'h1B, 8'h09);
    bus_read(3'd4, d);
    check("status_read_clear", d & 8'h1B, 8'h09);
    peek(3'd4, d);
    check("overrun_cleared", d[3], 0);
    for (int k = 0; k < 16; k++) begin
      bus_read(3'd0, d);
      check($sformatf("rx_burst_%0d", k), d, 8'h40 + k[7:0]);
    end
    check("rx_empty_after_burst", bus.rx_data_present, 0);

    rx_send(8'h77, 1'b0);
    repeat (20) @(negedge clk);
    peek(3'd4, d);
    check("frame_err_set", d & 8'h19, 8'h10);
    bus_read(3'd4, d);
    peek(3'd4, d);
    check("frame_err_cleared", d & 8'h19, 8'h00);

    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    peek(3'd4, d);
    check("glitch_ignored", d & 8'h19, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
